uart_bus_arbiter: RTL and testbench
===================================

# uart_bus_arbiter

Two-master arbiter and transaction sequencer for the shared system bus port. Master 0 is the UART bus bridge, master 1 the accelerator DMA; each presents one single-burst command (address, length, id, read/write), and the arbiter grants the bus round-robin. It drives the AW/AR address handshake, steers write beats and read data for the owner until the burst completes, and releases the bus after a watchdog timeout.

## Interface
- ADDR_W, 28, bus address width
- TIMEOUT, 255, maximum cycles one grant may hold the bus (ADDR+DATA)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- m_req_valid  in  2  per-master command valid, held until m_req_ready
- m_req_write  in  2  1 = write, 0 = read
- m_req_addr  in  2*ADDR_W  packed, master i at [i*ADDR_W +: ADDR_W]
- m_req_len  in  2*4  burst beats minus 1
- m_req_id  in  2*4  transaction id
- m_req_ready  out  2  one-cycle pulse: address accepted by bus
- m_wdata  in  2*32  write data per master
- m_wready  out  2  write beat consumed
- m_rvalid  out  2  read beat for master i
- m_rdata  out  32  read data, bus_rdata registered
- m_rlast  out  1  last read beat
- bus_awvalid, bus_awaddr[ADDR_W], bus_awlen[4], bus_awuserid[4], bus_awuserap  out  write address channel
- bus_awready  in  1
- bus_arvalid, bus_araddr[ADDR_W], bus_arlen[4], bus_aruserid[4], bus_aruserap  out  read address channel
- bus_arready  in  1
- bus_wdata  out  32; bus_wstrb  out  4
- bus_wready  in  1; bus_wlast  in  1
- bus_rvalid  in  1; bus_rlast  in  1; bus_rid  in  4; bus_rdata  in  32
- err_timeout  out  1  one-cycle pulse on watchdog release
- err_master  out  1  owner at last timeout (sticky until next timeout)

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: if any m_req_valid, grant → owner, capture write/addr/len/id into registers, clear watchdog, go ADDR. Both requesting: grant master != last_owner. last_owner resets to 1, so master 0 wins the first tie.
- ADDR: assert bus_awvalid (write) or bus_arvalid (read) from captured registers. Drive *userap = 1; drive *userid = captured id. Address/len/id are stable while valid. On valid&&ready: pulse m_req_ready[owner], drop valid, go DATA.
- DATA write: bus_wdata = m_wdata[owner] combinationally; bus_wstrb = 4'hf, else 0. m_wready[owner] = bus_wready; the other master sees 0. Complete on bus_wready && bus_wlast.
- DATA read: accept beats only when bus_rid == captured id. On a match, register m_rvalid[owner] = 1 and m_rdata/m_rlast from the bus. Beats with a mismatched id are ignored. Complete on an accepted beat with bus_rlast.
- On completion: last_owner ← owner, go IDLE.
- Watchdog increments every cycle in ADDR/DATA. The timeout limit is a count of TIMEOUT, so the counter is sized to reach TIMEOUT. On reaching TIMEOUT: drop all valids, pulse err_timeout, err_master ← owner, last_owner ← owner, go IDLE. m_req_ready is not pulsed if the timeout hits during ADDR.
- Reset values: state IDLE; all valids, m_req_ready, m_wready, m_rvalid, m_rlast, err_timeout = 0; addresses, len, id, m_rdata, bus_wstrb = 0; err_master = 0; watchdog = 0.
- Async reset mid-burst: everything returns to reset values immediately; the partial burst is abandoned.

## Timing
- Grant latency: a request first high in IDLE before edge k → bus_*valid high after edge k.
- Address phase is at least 1 cycle. Valid is held indefinitely until ready, bounded by the watchdog.
- m_req_ready pulses in the cycle after the handshake edge and lasts exactly 1 cycle.
- Write beat path is combinational (0 cycles). Read return is 1 cycle: bus beat at edge k → m_rvalid after edge k.
- Completion edge → IDLE. The next grant's valid appears 1 cycle later, so there is 1 idle bus cycle between back-to-back grants.
- A request arriving while another master owns the bus waits; no preemption.
- A requester must hold m_req_valid and its fields stable until m_req_ready. Deasserting early is a protocol violation; the captured command is still issued.

## Test plan
- Single write, master 0: addr 0x0000100, len 0, id 0xB, awready after 2 cycles, wready+wlast 1 cycle later → awaddr 0x0000100, awuserap 1, one m_req_ready[0] pulse, bus_wdata = m_wdata[0], wstrb 0xF, return to IDLE.
- Simultaneous requests after reset (m0 read, m1 write) → m0 granted first, m1 granted 1 idle cycle after m0's rlast; then a fresh tie → m0 again (last_owner = 1).
- Read 4 beats, id 0xB, with an interleaved beat of rid 0x3 → exactly 4 m_rvalid[0] pulses carrying the matching data, m_rlast on the 4th, m_rvalid[1] never asserted.
- Timeout: TIMEOUT = 16, arready never asserted → arvalid drops after 16 cycles, err_timeout pulses once, err_master = owner, the waiting master is granted next.
- rst_n low during DATA of a 4-beat write → all outputs 0 asynchronously; after release, a new request is granted normally.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Two-master round-robin arbiter and single-burst sequencer for the shared system bus port.
// Master 0 is the UART bus bridge and master 1 the accelerator DMA.
module uart_bus_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic [1:0]          m_req_valid,
    input  logic [1:0]          m_req_write,
    input  logic [2*ADDR_W-1:0] m_req_addr,
    input  logic [7:0]          m_req_len,
    input  logic [7:0]          m_req_id,
    output logic [1:0]          m_req_ready,
    input  logic [63:0]         m_wdata,
    output logic [1:0]          m_wready,
    output logic [1:0]          m_rvalid,
    output logic [31:0]         m_rdata,
    output logic                m_rlast,

    output logic                bus_awvalid,
    output logic [ADDR_W-1:0]   bus_awaddr,
    output logic [3:0]          bus_awlen,
    output logic [3:0]          bus_awuserid,
    output logic                bus_awuserap,
    input  logic                bus_awready,

    output logic                bus_arvalid,
    output logic [ADDR_W-1:0]   bus_araddr,
    output logic [3:0]          bus_arlen,
    output logic [3:0]          bus_aruserid,
    output logic                bus_aruserap,
    input  logic                bus_arready,

    output logic [31:0]         bus_wdata,
    output logic [3:0]          bus_wstrb,
    input  logic                bus_wready,
    input  logic                bus_wlast,

    input  logic                bus_rvalid,
    input  logic                bus_rlast,
    input  logic [3:0]          bus_rid,
    input  logic [31:0]         bus_rdata,

    output logic                err_timeout,
    output logic                err_master
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state;
    logic              owner;
    logic              lastOwner;
    logic              capWrite;
    logic [ADDR_W-1:0] capAddr;
    logic [3:0]        capLen;
    logic [3:0]        capId;
    logic [WD_W-1:0]   watchdog;

    logic              anyReq;
    logic              grantSel;
    logic              selWrite;
    logic [ADDR_W-1:0] selAddr;
    logic [3:0]        selLen;
    logic [3:0]        selId;
    logic              inAddr;
    logic              inData;
    logic              busy;
    logic              addrHandshake;
    logic              writeBeat;
    logic              writeDone;
    logic              readBeat;
    logic              readDone;
    logic [WD_W-1:0]   wdNext;
    logic              timeoutHit;
    logic [1:0]        ownerMask;

    // A tie goes to the master that did not own the bus last; a lone requester always wins.
    assign anyReq   = |m_req_valid;
    assign grantSel = (&m_req_valid) ? ~lastOwner : m_req_valid[1];

    assign selWrite = grantSel ? m_req_write[1]              : m_req_write[0];
    assign selAddr  = grantSel ? m_req_addr[2*ADDR_W-1:ADDR_W] : m_req_addr[ADDR_W-1:0];
    assign selLen   = grantSel ? m_req_len[7:4]              : m_req_len[3:0];
    assign selId    = grantSel ? m_req_id[7:4]               : m_req_id[3:0];

    assign inAddr    = (state == ADDR);
    assign inData    = (state == DATA);
    assign busy      = inAddr || inData;
    assign ownerMask = owner ? 2'b10 : 2'b01;

    assign addrHandshake = inAddr && (capWrite ? bus_awready : bus_arready);
    assign writeBeat     = inData && capWrite && bus_wready;
    assign writeDone     = writeBeat && bus_wlast;
    assign readBeat      = inData && !capWrite && bus_rvalid && (bus_rid == capId);
    assign readDone      = readBeat && bus_rlast;

    // The watchdog fires on the edge at which the grant has held the bus for TIMEOUT cycles.
    assign wdNext     = watchdog + WD_W'(1);
    assign timeoutHit = busy && (wdNext == WD_W'(TIMEOUT));

    assign bus_awvalid  = inAddr && capWrite;
    assign bus_awaddr   = capAddr;
    assign bus_awlen    = capLen;
    assign bus_awuserid = capId;
    assign bus_awuserap = bus_awvalid;

    assign bus_arvalid  = inAddr && !capWrite;
    assign bus_araddr   = capAddr;
    assign bus_arlen    = capLen;
    assign bus_aruserid = capId;
    assign bus_aruserap = bus_arvalid;

    // Write beats pass straight through from the owner; the non-owner never sees wready.
    assign bus_wdata = (inData && capWrite) ? (owner ? m_wdata[63:32] : m_wdata[31:0]) : 32'h0;
    assign bus_wstrb = (inData && capWrite) ? 4'hf : 4'h0;
    assign m_wready  = writeBeat ? ownerMask : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (anyReq) state <= ADDR;
                ADDR: begin
                    if (timeoutHit)         state <= IDLE;
                    else if (addrHandshake) state <= DATA;
                end
                DATA: begin
                    if (timeoutHit || writeDone || readDone) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command capture happens only at grant, so a requester dropping early still gets issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= 1'b0;
            capWrite <= 1'b0;
            capAddr  <= '0;
            capLen   <= 4'h0;
            capId    <= 4'h0;
        end else if (state == IDLE && anyReq) begin
            owner    <= grantSel;
            capWrite <= selWrite;
            capAddr  <= selAddr;
            capLen   <= selLen;
            capId    <= selId;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            watchdog <= '0;
        end else if (state == IDLE) begin
            watchdog <= '0;
        end else begin
            watchdog <= wdNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastOwner <= 1'b1;
        end else if (timeoutHit || writeDone || readDone) begin
            lastOwner <= owner;
        end
    end

    // The watchdog outranks a handshake landing on the same edge, so no ready pulse then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req_ready <= 2'b00;
        end else if (addrHandshake && !timeoutHit) begin
            m_req_ready <= ownerMask;
        end else begin
            m_req_ready <= 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rvalid <= 2'b00;
            m_rlast  <= 1'b0;
            m_rdata  <= 32'h0;
        end else if (readBeat && !timeoutHit) begin
            m_rvalid <= ownerMask;
            m_rlast  <= bus_rlast;
            m_rdata  <= bus_rdata;
        end else begin
            m_rvalid <= 2'b00;
            m_rlast  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
            err_master  <= 1'b0;
        end else if (timeoutHit) begin
            err_timeout <= 1'b1;
            err_master  <= owner;
        end else begin
            err_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed self-checking bench for uart_bus_arbiter, built with a 16-cycle watchdog.
module tb_uart_bus_arbiter;

    localparam int ADDR_W  = 28;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          m_req_valid;
    logic [1:0]          m_req_write;
    logic [2*ADDR_W-1:0] m_req_addr;
    logic [7:0]          m_req_len;
    logic [7:0]          m_req_id;
    logic [1:0]          m_req_ready;
    logic [63:0]         m_wdata;
    logic [1:0]          m_wready;
    logic [1:0]          m_rvalid;
    logic [31:0]         m_rdata;
    logic                m_rlast;
    logic                bus_awvalid;
    logic [ADDR_W-1:0]   bus_awaddr;
    logic [3:0]          bus_awlen;
    logic [3:0]          bus_awuserid;
    logic                bus_awuserap;
    logic                bus_awready;
    logic                bus_arvalid;
    logic [ADDR_W-1:0]   bus_araddr;
    logic [3:0]          bus_arlen;
    logic [3:0]          bus_aruserid;
    logic                bus_aruserap;
    logic                bus_arready;
    logic [31:0]         bus_wdata;
    logic [3:0]          bus_wstrb;
    logic                bus_wready;
    logic                bus_wlast;
    logic                bus_rvalid;
    logic                bus_rlast;
    logic [3:0]          bus_rid;
    logic [31:0]         bus_rdata;
    logic                err_timeout;
    logic                err_master;

    int compareCount  = 0;
    int mismatchCount = 0;

    logic [3:0]  beatId   [5] = '{4'hB, 4'h3, 4'hB, 4'hB, 4'hB};
    logic [31:0] beatData [5] = '{32'h1111_0001, 32'h9999_9999, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
    logic        beatLast [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    uart_bus_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
        .m_req_len(m_req_len), .m_req_id(m_req_id), .m_req_ready(m_req_ready),
        .m_wdata(m_wdata), .m_wready(m_wready), .m_rvalid(m_rvalid),
        .m_rdata(m_rdata), .m_rlast(m_rlast),
        .bus_awvalid(bus_awvalid), .bus_awaddr(bus_awaddr), .bus_awlen(bus_awlen),
        .bus_awuserid(bus_awuserid), .bus_awuserap(bus_awuserap), .bus_awready(bus_awready),
        .bus_arvalid(bus_arvalid), .bus_araddr(bus_araddr), .bus_arlen(bus_arlen),
        .bus_aruserid(bus_aruserid), .bus_aruserap(bus_aruserap), .bus_arready(bus_arready),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wready(bus_wready), .bus_wlast(bus_wlast),
        .bus_rvalid(bus_rvalid), .bus_rlast(bus_rlast), .bus_rid(bus_rid), .bus_rdata(bus_rdata),
        .err_timeout(err_timeout), .err_master(err_master)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int m, input logic wr, input logic [ADDR_W-1:0] addr,
                                 input logic [3:0] len, input logic [3:0] id);
        m_req_valid[m]                  = 1'b1;
        m_req_write[m]                  = wr;
        m_req_addr[m*ADDR_W +: ADDR_W]  = addr;
        m_req_len[m*4 +: 4]             = len;
        m_req_id[m*4 +: 4]              = id;
    endtask

    task automatic clearInputs();
        m_req_valid = 2'b00;
        m_req_write = 2'b00;
        m_req_addr  = '0;
        m_req_len   = 8'h0;
        m_req_id    = 8'h0;
        bus_awready = 1'b0;
        bus_arready = 1'b0;
        bus_wready  = 1'b0;
        bus_wlast   = 1'b0;
        bus_rvalid  = 1'b0;
        bus_rlast   = 1'b0;
        bus_rid     = 4'h0;
        bus_rdata   = 32'h0;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        clearInputs();
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit: observed still running, expected finished");
        $fatal(1, "[TB] time limit");
    end

    initial begin
        int pulses;
        int highCycles;
        bit dropped;
        logic [31:0] lastData;

        m_wdata = {32'h1234_5678, 32'hDEAD_BEEF};
        resetDut();

        // Reset state
        checkOutput("rst_awvalid", bus_awvalid, 0);
        checkOutput("rst_arvalid", bus_arvalid, 0);
        checkOutput("rst_req_ready", m_req_ready, 0);
        checkOutput("rst_wstrb", bus_wstrb, 0);
        checkOutput("rst_rdata", m_rdata, 0);
        checkOutput("rst_err_master", err_master, 0);

        // Single write from master 0 with a delayed awready
        applyStimulus(0, 1'b1, 28'h0000100, 4'h0, 4'hB);
        step();
        checkOutput("w_awvalid", bus_awvalid, 1);
        checkOutput("w_awaddr", bus_awaddr, 28'h0000100);
        checkOutput("w_awuserap", bus_awuserap, 1);
        checkOutput("w_awuserid", bus_awuserid, 4'hB);
        checkOutput("w_awlen", bus_awlen, 0);
        checkOutput("w_arvalid", bus_arvalid, 0);
        step();
        checkOutput("w_awvalid_held", bus_awvalid, 1);
        checkOutput("w_no_early_ready", m_req_ready, 0);
        bus_awready = 1'b1;
        step();
        bus_awready = 1'b0;
        checkOutput("w_req_ready", m_req_ready, 2'b01);
        checkOutput("w_awvalid_drop", bus_awvalid, 0);
        m_req_valid[0] = 1'b0;
        checkOutput("w_wstrb", bus_wstrb, 4'hF);
        checkOutput("w_wdata", bus_wdata, 32'hDEAD_BEEF);
        bus_wready = 1'b1;
        bus_wlast  = 1'b1;
        #1;
        checkOutput("w_m_wready", m_wready, 2'b01);
        step();
        bus_wready = 1'b0;
        bus_wlast  = 1'b0;
        checkOutput("w_req_ready_pulse_end", m_req_ready, 0);
        checkOutput("w_idle_wstrb", bus_wstrb, 0);
        checkOutput("w_idle_awvalid", bus_awvalid, 0);

        // Simultaneous requests right after reset: master 0 wins, master 1 follows
        resetDut();
        applyStimulus(0, 1'b0, 28'h0000200, 4'h0, 4'h1);
        applyStimulus(1, 1'b1, 28'h0000300, 4'h0, 4'h2);
        step();
        checkOutput("tie_arvalid", bus_arvalid, 1);
        checkOutput("tie_awvalid", bus_awvalid, 0);
        checkOutput("tie_araddr", bus_araddr, 28'h0000200);
        checkOutput("tie_aruserap", bus_aruserap, 1);
        bus_arready = 1'b1;
        step();
        bus_arready = 1'b0;
        checkOutput("tie_req_ready0", m_req_ready, 2'b01);
        m_req_valid[0] = 1'b0;
        bus_rvalid = 1'b1;
        bus_rid    = 4'h1;
        bus_rlast  = 1'b1;
        bus_rdata  = 32'h0000_A5A5;
        step();
        bus_rvalid = 1'b0;
        bus_rlast  = 1'b0;
        checkOutput("tie_rvalid", m_rvalid, 2'b01);
        checkOutput("tie_rdata", m_rdata, 32'h0000_A5A5);
        checkOutput("tie_rlast", m_rlast, 1);
        checkOutput("tie_idle_gap", bus_awvalid, 0);
        step();
        checkOutput("tie_m1_awvalid", bus_awvalid, 1);
        checkOutput("tie_m1_awaddr", bus_awaddr, 28'h0000300);
        bus_awready = 1'b1;
        step();
        bus_awready = 1'b0;
        checkOutput("tie_req_ready1", m_req_ready, 2'b10);
        m_req_valid[1] = 1'b0;
        checkOutput("tie_m1_wdata", bus_wdata, 32'h1234_5678);
        bus_wready = 1'b1;
        bus_wlast  = 1'b1;
        #1;
        checkOutput("tie_m1_wready", m_wready, 2'b10);
        step();
        bus_wready = 1'b0;
        bus_wlast  = 1'b0;
        applyStimulus(0, 1'b0, 28'h0000400, 4'h0, 4'h4);
        applyStimulus(1, 1'b1, 28'h0000500, 4'h0, 4'h5);
        step();
        checkOutput("tie2_arvalid", bus_arvalid, 1);
        checkOutput("tie2_araddr", bus_araddr, 28'h0000400);
        checkOutput("tie2_awvalid", bus_awvalid, 0);
        bus_arready = 1'b1;
        step();
        bus_arready = 1'b0;
        m_req_valid = 2'b00;
        bus_rvalid = 1'b1;
        bus_rid    = 4'h4;
        bus_rlast  = 1'b1;
        step();
        bus_rvalid = 1'b0;
        bus_rlast  = 1'b0;
        step();

        // Four-beat read with a foreign-id beat interleaved
        applyStimulus(0, 1'b0, 28'h0000600, 4'h3, 4'hB);
        step();
        checkOutput("rd_arlen", bus_arlen, 4'h3);
        bus_arready = 1'b1;
        step();
        bus_arready = 1'b0;
        m_req_valid[0] = 1'b0;
        pulses   = 0;
        lastData = 32'h0000_A5A5;
        for (int i = 0; i < 5; i++) begin
            bus_rvalid = 1'b1;
            bus_rid    = beatId[i];
            bus_rdata  = beatData[i];
            bus_rlast  = beatLast[i];
            step();
            if (m_rvalid[0]) pulses++;
            if (beatId[i] == 4'hB) lastData = beatData[i];
            checkOutput($sformatf("rd_rvalid_%0d", i), m_rvalid, (beatId[i] == 4'hB) ? 2'b01 : 2'b00);
            checkOutput($sformatf("rd_rdata_%0d", i), m_rdata, lastData);
            checkOutput($sformatf("rd_rlast_%0d", i), m_rlast, beatLast[i]);
        end
        bus_rvalid = 1'b0;
        bus_rlast  = 1'b0;
        checkOutput("rd_pulses", pulses, 4);
        step();
        checkOutput("rd_rvalid_after", m_rvalid, 0);

        // Watchdog: master 1 read never sees arready while master 0 waits
        applyStimulus(1, 1'b0, 28'h0ABCDEF, 4'h0, 4'h5);
        step();
        checkOutput("to_arvalid", bus_arvalid, 1);
        checkOutput("to_araddr", bus_araddr, 28'h0ABCDEF);
        checkOutput("to_aruserid", bus_aruserid, 4'h5);
        applyStimulus(0, 1'b1, 28'h0000777, 4'h3, 4'h7);
        highCycles = 1;
        dropped    = 1'b0;
        for (int i = 0; i < 40 && !dropped; i++) begin
            step();
            if (bus_arvalid) highCycles++;
            else dropped = 1'b1;
        end
        checkOutput("to_dropped", dropped, 1);
        checkOutput("to_arvalid_cycles", highCycles, TIMEOUT);
        checkOutput("to_err_timeout", err_timeout, 1);
        checkOutput("to_err_master", err_master, 1);
        checkOutput("to_no_req_ready", m_req_ready, 0);
        step();
        checkOutput("to_err_pulse_end", err_timeout, 0);
        checkOutput("to_err_master_sticky", err_master, 1);
        checkOutput("to_waiter_awvalid", bus_awvalid, 1);
        checkOutput("to_waiter_awaddr", bus_awaddr, 28'h0000777);
        m_req_valid[1] = 1'b0;

        // Asynchronous reset in the middle of a four-beat write
        bus_awready = 1'b1;
        step();
        bus_awready = 1'b0;
        checkOutput("ar_req_ready", m_req_ready, 2'b01);
        m_req_valid[0] = 1'b0;
        bus_wready = 1'b1;
        step();
        step();
        checkOutput("ar_wstrb_before", bus_wstrb, 4'hF);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_wstrb", bus_wstrb, 0);
        checkOutput("ar_wdata", bus_wdata, 0);
        checkOutput("ar_m_wready", m_wready, 0);
        checkOutput("ar_awaddr", bus_awaddr, 0);
        checkOutput("ar_err_master", err_master, 0);
        clearInputs();
        step();
        rst_n = 1'b1;
        applyStimulus(1, 1'b1, 28'h0000700, 4'h0, 4'h9);
        step();
        checkOutput("ar_new_awvalid", bus_awvalid, 1);
        checkOutput("ar_new_awaddr", bus_awaddr, 28'h0000700);
        checkOutput("ar_new_awuserid", bus_awuserid, 4'h9);
        bus_awready = 1'b1;
        step();
        bus_awready = 1'b0;
        checkOutput("ar_new_req_ready", m_req_ready, 2'b10);
        m_req_valid = 2'b00;
        bus_wready = 1'b1;
        bus_wlast  = 1'b1;
        step();
        clearInputs();
        checkOutput("ar_new_done", bus_wstrb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
